// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: pipeline writeback has priority, LLU results
// are buffered in a small FIFO and drained into idle slots; a pending-destination
// scoreboard stalls decode on hazards against in-flight LLU results.
module rf_wb_sched #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  output logic        iss_ready,
  input  logic        res_valid,
  input  logic [4:0]  res_wa,
  input  logic [31:0] res_wd,
  output logic        res_ready,
  input  logic [4:0]  dec_ra1,
  input  logic [4:0]  dec_ra2,
  input  logic        dec_we,
  input  logic [4:0]  dec_wa,
  output logic        stall,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [31:0] pending,
  output logic        err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(STARVE_MAX + 1);

  logic [4:0]    fifo_wa [DEPTH];
  logic [31:0]   fifo_wd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] age, age_nxt;
  logic [31:0]   pend_q, set_vec, clr_vec;
  logic          err_q, err_nxt;

  logic          empty, full, busy, accept, push, pop, iss_take;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign busy    = wb_we && (wb_wa != 5'd0);
  assign head_wa = fifo_wa[rd_ptr];
  assign head_wd = fifo_wd[rd_ptr];

  // Results to $0 are acknowledged but never stored.
  assign accept  = res_valid && !full;
  assign push    = accept && (res_wa != 5'd0);
  assign pop     = !busy && !empty;

  assign res_ready = !full;
  assign iss_ready = (iss_wa == 5'd0) || !pend_q[iss_wa];
  assign iss_take  = iss_valid && iss_ready && (iss_wa != 5'd0);
  assign pending   = pend_q;
  assign err       = err_q;

  // Zero-latency write-port mux.
  always_comb begin
    we3 = wb_we;
    wa3 = wb_wa;
    wd3 = wb_wd;
    if (!busy && !empty) begin
      we3 = 1'b1;
      wa3 = head_wa;
      wd3 = head_wd;
    end
  end

  always_comb begin
    stall = 1'b0;
    if ((dec_ra1 != 5'd0) && pend_q[dec_ra1]) stall = 1'b1;
    if ((dec_ra2 != 5'd0) && pend_q[dec_ra2]) stall = 1'b1;
    if (dec_we && (dec_wa != 5'd0) && pend_q[dec_wa]) stall = 1'b1;
    if (age == AW'(STARVE_MAX)) stall = 1'b1;
    if (full) stall = 1'b1;
  end

  // Scoreboard and sticky error next-state.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    err_nxt = err_q;
    if (iss_take) set_vec = 32'(1) << iss_wa;
    if (pop) begin
      clr_vec = 32'(1) << head_wa;
      if (!pend_q[head_wa]) err_nxt = 1'b1;
    end
    if (push && !pend_q[res_wa]) err_nxt = 1'b1;
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // Head-of-line age, saturating at STARVE_MAX.
  always_comb begin
    age_nxt = age;
    if (empty || pop)                age_nxt = '0;
    else if (age != AW'(STARVE_MAX)) age_nxt = age + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= res_wa;
      fifo_wd[wr_ptr] <= res_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      age    <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      age    <= age_nxt;
      pend_q <= (pend_q & ~clr_vec) | set_vec;
      err_q  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: directed scenarios then randomized traffic, all checked
// against a queue-based reference model of the scheduler.
module tb_rf_wb_sched;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned SMAX  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic        iss_ready;
  logic        res_valid;
  logic [4:0]  res_wa;
  logic [31:0] res_wd;
  logic        res_ready;
  logic [4:0]  dec_ra1, dec_ra2, dec_wa;
  logic        dec_we;
  logic        stall;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        err;

  always #5 clk = ~clk;

  rf_wb_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_ready(iss_ready),
    .res_valid(res_valid), .res_wa(res_wa), .res_wd(res_wd), .res_ready(res_ready),
    .dec_ra1(dec_ra1), .dec_ra2(dec_ra2), .dec_we(dec_we), .dec_wa(dec_wa),
    .stall(stall), .we3(we3), .wa3(wa3), .wd3(wd3),
    .pending(pending), .err(err)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  ent_t       mq[$];
  bit         mpend[32];
  bit         merr;
  int         mage;
  logic [4:0] llu_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    llu_q.delete();
    foreach (mpend[i]) mpend[i] = 1'b0;
    merr = 1'b0;
    mage = 0;
  endtask

  // Let combinational outputs settle, then compare all outputs with the model.
  task automatic settle_check(input string tag);
    bit          busy, e_we, e_stall;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pend;
    #1;
    busy = wb_we && (wb_wa != 0);
    if (busy || mq.size() == 0) begin
      e_we = busy ? 1'b1 : wb_we;
      e_wa = wb_wa;
      e_wd = wb_wd;
    end else begin
      e_we = 1'b1;
      e_wa = mq[0].wa;
      e_wd = mq[0].wd;
    end
    for (int i = 0; i < 32; i++) e_pend[i] = mpend[i];
    e_stall = (dec_ra1 != 0 && mpend[dec_ra1]) || (dec_ra2 != 0 && mpend[dec_ra2]) ||
              (dec_we && dec_wa != 0 && mpend[dec_wa]) || (mage == SMAX) ||
              (mq.size() == DEPTH);
    chk({tag, ".we3"}, 32'(we3), 32'(e_we));
    if (e_we) begin
      chk({tag, ".wa3"}, 32'(wa3), 32'(e_wa));
      chk({tag, ".wd3"}, wd3, e_wd);
    end
    chk({tag, ".res_ready"}, 32'(res_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".iss_ready"}, 32'(iss_ready), 32'(iss_wa == 0 || !mpend[iss_wa]));
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".pending"}, pending, e_pend);
    chk({tag, ".err"}, 32'(err), 32'(merr));
  endtask

  // Clock edge: advance the model with the inputs held across the edge.
  task automatic advance();
    bit   busy, pop, acc, iss_ok;
    int   age_n;
    ent_t e;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      busy   = wb_we && (wb_wa != 0);
      pop    = !busy && mq.size() > 0;
      acc    = res_valid && mq.size() < DEPTH;
      iss_ok = iss_valid && iss_wa != 0 && !mpend[iss_wa];
      age_n  = (mq.size() == 0 || pop) ? 0 : ((mage < SMAX) ? mage + 1 : SMAX);
      if (acc && res_wa != 0) begin
        if (!mpend[res_wa]) merr = 1'b1;
      end
      if (pop) begin
        e = mq.pop_front();
        if (!mpend[e.wa]) merr = 1'b1;
        mpend[e.wa] = 1'b0;
      end
      if (acc && res_wa != 0) begin
        e.wa = res_wa;
        e.wd = res_wd;
        mq.push_back(e);
      end
      if (acc) begin
        for (int i = 0; i < llu_q.size(); i++)
          if (llu_q[i] == res_wa) begin
            llu_q.delete(i);
            break;
          end
      end
      if (iss_ok) begin
        mpend[iss_wa] = 1'b1;
        llu_q.push_back(iss_wa);
      end
      mage = age_n;
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    settle_check(tag);
    advance();
  endtask

  initial begin
    reset = 1'b1; wb_we = 0; wb_wa = 0; wb_wd = 0;
    iss_valid = 0; iss_wa = 0; res_valid = 0; res_wa = 0; res_wd = 0;
    dec_ra1 = 0; dec_ra2 = 0; dec_we = 0; dec_wa = 0;
    model_reset();
    @(negedge clk);
    advance();
    reset = 1'b0;

    // Writeback passes through combinationally.
    wb_we = 1; wb_wa = 5; wb_wd = 32'h1234;
    settle_check("wb_pass");
    chk("wb_pass.wa3_const", 32'(wa3), 32'd5);
    chk("wb_pass.wd3_const", wd3, 32'h1234);
    chk("wb_pass.pending0", pending, 32'd0);
    advance();

    // Reserve $8, hazard stall, duplicate reservation refused, result drains.
    wb_we = 0; iss_valid = 1; iss_wa = 8;
    step("iss8");
    iss_valid = 0; dec_ra1 = 8;
    settle_check("raw8");
    chk("raw8.stall_const", 32'(stall), 32'd1);
    advance();
    iss_valid = 1; iss_wa = 8;
    settle_check("dup8");
    chk("dup8.iss_ready_const", 32'(iss_ready), 32'd0);
    advance();
    iss_valid = 0; res_valid = 1; res_wa = 8; res_wd = 32'hCAFE;
    step("res8");
    res_valid = 0;
    settle_check("wr8");
    chk("wr8.wa3_const", 32'(wa3), 32'd8);
    chk("wr8.wd3_const", wd3, 32'hCAFE);
    advance();
    settle_check("clr8");
    chk("clr8.stall_const", 32'(stall), 32'd0);
    advance();
    iss_valid = 1; iss_wa = 8;
    settle_check("reiss8");
    chk("reiss8.iss_ready_const", 32'(iss_ready), 32'd1);
    advance();
    iss_valid = 0; dec_ra1 = 0;

    // Starvation: continuous writeback keeps the head waiting.
    wb_we = 1; wb_wa = 5; wb_wd = 32'h55;
    res_valid = 1; res_wa = 8; res_wd = 32'hBEEF;
    step("starve_push");
    res_valid = 0;
    for (int i = 0; i < 4; i++) step("starve_wait");
    settle_check("starve_max");
    chk("starve_max.stall_const", 32'(stall), 32'd1);
    advance();
    wb_we = 0;
    settle_check("starve_drain");
    chk("starve_drain.wa3_const", 32'(wa3), 32'd8);
    advance();
    settle_check("starve_clear");
    chk("starve_clear.stall_const", 32'(stall), 32'd0);
    advance();

    // Fill the FIFO behind busy writeback, then drain in order.
    wb_we = 1; wb_wa = 6;
    iss_valid = 1; iss_wa = 10; step("iss10");
    iss_wa = 11; step("iss11");
    iss_valid = 0;
    res_valid = 1; res_wa = 10; res_wd = 32'hA0; step("res10");
    res_wa = 11; res_wd = 32'hB0; step("res11");
    res_valid = 0;
    settle_check("full");
    chk("full.res_ready_const", 32'(res_ready), 32'd0);
    chk("full.stall_const", 32'(stall), 32'd1);
    advance();
    wb_we = 0;
    settle_check("drain1");
    chk("drain1.wa3_const", 32'(wa3), 32'd10);
    advance();
    settle_check("drain2");
    chk("drain2.wa3_const", 32'(wa3), 32'd11);
    advance();
    step("drained");

    // Unreserved result sets sticky err; $0 results are dropped.
    res_valid = 1; res_wa = 3; res_wd = 32'h33; step("res3");
    res_valid = 0;
    settle_check("wr3");
    chk("wr3.wa3_const", 32'(wa3), 32'd3);
    chk("wr3.err_const", 32'(err), 32'd1);
    advance();
    res_valid = 1; res_wa = 0; res_wd = 32'hDEAD; step("res0");
    res_valid = 0;
    settle_check("res0_drop");
    chk("res0_drop.we3_const", 32'(we3), 32'd0);
    chk("res0_drop.err_sticky", 32'(err), 32'd1);
    advance();

    // Reset with two results buffered.
    wb_we = 1; wb_wa = 7;
    iss_valid = 1; iss_wa = 12; step("iss12");
    iss_wa = 13; step("iss13");
    iss_valid = 0; res_valid = 1; res_wa = 12; step("res12");
    res_wa = 13; step("res13");
    res_valid = 0; reset = 1; step("rst_mid");
    reset = 0; wb_we = 0;
    settle_check("post_rst");
    chk("post_rst.pending_const", pending, 32'd0);
    chk("post_rst.err_const", 32'(err), 32'd0);
    chk("post_rst.we3_const", 32'(we3), 32'd0);
    chk("post_rst.res_ready_const", 32'(res_ready), 32'd1);
    advance();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 249) == 0);
      wb_we     = ($urandom_range(0, 99) < 50);
      wb_wa     = 5'($urandom_range(0, 15));
      wb_wd     = $urandom;
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_wa    = 5'($urandom_range(0, 15));
      res_wd    = $urandom;
      if (llu_q.size() > 0 && $urandom_range(0, 99) < 40) begin
        res_valid = 1;
        res_wa    = llu_q[$urandom_range(0, llu_q.size() - 1)];
      end else if ($urandom_range(0, 199) == 0) begin
        res_valid = 1;
        res_wa    = 5'($urandom_range(0, 15));
      end else begin
        res_valid = 0;
        res_wa    = 5'($urandom_range(0, 31));
      end
      dec_ra1 = 5'($urandom_range(0, 15));
      dec_ra2 = 5'($urandom_range(0, 15));
      dec_we  = 1'($urandom_range(0, 1));
      dec_wa  = 5'($urandom_range(0, 15));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
